// File: rtl/ball_motion_ctrl.sv
// Ball motion sequencer.
// Issues one 4-bit movement control word per frame step for the ball register.
// It also detects wall bounces, paddle hits and misses, runs the serve
// countdown and pulses the score outputs.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | parked; waits for game_en on a frame tick
// SERVE  | counts SERVE_FRAMES frame ticks before the ball is released
// MOVE   | one bounce/hit/miss evaluation per frame tick
// SCORE  | one cycle: recentre, pulse score, aim next serve at loser
module ball_motion_ctrl #(
   parameter logic [9:0] TOP_WALL     = 10'd8,
   parameter logic [9:0] BOTTOM_WALL  = 10'd472,
   parameter logic [9:0] LEFT_PAD_X   = 10'd16,
   parameter logic [9:0] RIGHT_PAD_X  = 10'd624,
   parameter logic [9:0] PAD_HALF     = 10'd32,
   parameter logic [9:0] BALL_HALF    = 10'd4,
   parameter logic [7:0] SERVE_FRAMES = 8'd120
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       game_en,
   input  logic [9:0] ball_center_x,
   input  logic [9:0] ball_center_y,
   input  logic [9:0] paddle_l_y,
   input  logic [9:0] paddle_r_y,
   output logic [3:0] cw_ballMovement,
   output logic       score_l,
   output logic       score_r,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_MOVE  = 2'd2,
      ST_SCORE = 2'd3
   } state_t;

   localparam logic [3:0] CW_HOLD     = 4'b0000;
   localparam logic [3:0] CW_DR       = 4'b0001;
   localparam logic [3:0] CW_UL       = 4'b0010;
   localparam logic [3:0] CW_DL       = 4'b0011;
   localparam logic [3:0] CW_UR       = 4'b0100;
   localparam logic [3:0] CW_RECENTRE = 4'b0101;

   // Paddle reach: centre distance at which ball and paddle still overlap.
   localparam logic [10:0] REACH = {1'b0, PAD_HALF} + {1'b0, BALL_HALF};

   // Direction encoding: dx 1 = right, 0 = left; dy 1 = down, 0 = up.
   state_t      state_q;
   logic [7:0]  cnt_q;
   logic        dx_q;
   logic        dy_q;
   logic        win_l_q;   // latched on a miss: 1 = left player scores
   logic [3:0]  cw_q;
   logic        score_l_q;
   logic        score_r_q;

   logic        top_hit;
   logic        bot_hit;
   logic        left_contact;
   logic        right_contact;
   logic [10:0] bot_edge;
   logic [10:0] right_edge;
   logic [10:0] diff_l;
   logic [10:0] diff_r;
   logic        hit_l;
   logic        hit_r;
   logic        move_dx_d;
   logic        move_dy_d;
   logic        miss_d;
   logic        miss_win_l_d;

   function automatic logic [3:0] dir_code(input logic dx, input logic dy);
      logic [3:0] c;
      case ({dx, dy})
         2'b11:   c = CW_DR;
         2'b00:   c = CW_UL;
         2'b01:   c = CW_DL;
         default: c = CW_UR;
      endcase
      return c;
   endfunction

   // Evaluate bounce / paddle outcome against the current ball and paddle inputs.
   always_comb begin
      bot_edge      = {1'b0, ball_center_y} + {1'b0, BALL_HALF};
      right_edge    = {1'b0, ball_center_x} + {1'b0, BALL_HALF};
      // A centre closer than BALL_HALF to zero would wrap; that is a top/left contact anyway.
      top_hit       = (ball_center_y < BALL_HALF) ||
                      ((ball_center_y - BALL_HALF) <= TOP_WALL);
      bot_hit       = bot_edge >= {1'b0, BOTTOM_WALL};
      left_contact  = (ball_center_x < BALL_HALF) ||
                      ((ball_center_x - BALL_HALF) <= LEFT_PAD_X);
      right_contact = right_edge >= {1'b0, RIGHT_PAD_X};

      diff_l = (ball_center_y >= paddle_l_y) ?
               {1'b0, ball_center_y - paddle_l_y} : {1'b0, paddle_l_y - ball_center_y};
      diff_r = (ball_center_y >= paddle_r_y) ?
               {1'b0, ball_center_y - paddle_r_y} : {1'b0, paddle_r_y - ball_center_y};
      hit_l  = diff_l <= REACH;
      hit_r  = diff_r <= REACH;

      move_dy_d = dy_q;
      if (top_hit) begin
         move_dy_d = 1'b1;
      end else if (bot_hit) begin
         move_dy_d = 1'b0;
      end

      move_dx_d    = dx_q;
      miss_d       = 1'b0;
      miss_win_l_d = 1'b0;
      if (!dx_q && left_contact) begin
         if (hit_l) begin
            move_dx_d = 1'b1;
         end else begin
            miss_d       = 1'b1;
            miss_win_l_d = 1'b0;
         end
      end else if (dx_q && right_contact) begin
         if (hit_r) begin
            move_dx_d = 1'b0;
         end else begin
            miss_d       = 1'b1;
            miss_win_l_d = 1'b1;
         end
      end
   end

   // Sequencer FSM with registered control word and score pulses.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 8'd0;
         dx_q      <= 1'b1;
         dy_q      <= 1'b1;
         win_l_q   <= 1'b0;
         cw_q      <= CW_HOLD;
         score_l_q <= 1'b0;
         score_r_q <= 1'b0;
      end else begin
         cw_q      <= CW_HOLD;
         score_l_q <= 1'b0;
         score_r_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (frame_tick && game_en) begin
                  state_q <= ST_SERVE;
                  cnt_q   <= 8'd0;
               end
            end
            ST_SERVE: begin
               if (!game_en) begin
                  cw_q    <= CW_RECENTRE;
                  state_q <= ST_IDLE;
               end else if (frame_tick) begin
                  if (cnt_q == SERVE_FRAMES - 8'd1) begin
                     state_q <= ST_MOVE;
                  end
                  if (cnt_q != 8'hFF) begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
            end
            ST_MOVE: begin
               if (!game_en) begin
                  cw_q    <= CW_RECENTRE;
                  state_q <= ST_IDLE;
               end else if (frame_tick) begin
                  dy_q <= move_dy_d;
                  if (miss_d) begin
                     win_l_q <= miss_win_l_d;
                     state_q <= ST_SCORE;
                  end else begin
                     dx_q <= move_dx_d;
                     cw_q <= dir_code(move_dx_d, move_dy_d);
                  end
               end
            end
            default: begin
               if (!game_en) begin
                  cw_q    <= CW_RECENTRE;
                  state_q <= ST_IDLE;
               end else begin
                  cw_q      <= CW_RECENTRE;
                  score_l_q <= win_l_q;
                  score_r_q <= !win_l_q;
                  // Next serve heads toward whoever conceded.
                  dx_q      <= win_l_q;
                  dy_q      <= 1'b1;
                  cnt_q     <= 8'd0;
                  state_q   <= ST_SERVE;
               end
            end
         endcase
      end
   end

   assign cw_ballMovement = cw_q;
   assign score_l         = score_l_q;
   assign score_r         = score_r_q;
   assign state_o         = state_q;

endmodule
